// File: rtl/sram_like_arbiter.sv
// Merges NUM_CH sram-like masters onto one downstream port; request and response paths add 0 cycles.
// A stalled grant (m_addr_ok low) is held until accepted; no new grant once MAX_OUTST are in flight.
module sram_like_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0]              ch_wr,
  input  logic [2*NUM_CH-1:0]            ch_size,
  input  logic [ADDR_W*NUM_CH-1:0]       ch_addr,
  input  logic [DATA_W*NUM_CH-1:0]       ch_wdata,
  output logic [NUM_CH-1:0]              ch_addr_ok,
  output logic [NUM_CH-1:0]              ch_data_ok,
  output logic [DATA_W-1:0]              ch_rdata,
  output logic                           m_req,
  output logic                           m_wr,
  output logic [1:0]                     m_size,
  output logic [ADDR_W-1:0]              m_addr,
  output logic [DATA_W-1:0]              m_wdata,
  input  logic                           m_addr_ok,
  input  logic                           m_data_ok,
  input  logic [DATA_W-1:0]              m_rdata,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
  output logic                           resp_err
);
  localparam int GW = $clog2(NUM_CH);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = $clog2(MAX_OUTST + 1);

  typedef enum logic {IDLE, LOCK} state_t;
  state_t state_q, state_d;

  logic [GW-1:0] lock_g_q, rr_ptr_q, arb_g, arb_idx, sel_g, head_g;
  logic          arb_found, full, empty, accept, pop;
  logic [GW-1:0] ord_mem [MAX_OUTST];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;

  logic              wr_a    [NUM_CH];
  logic [1:0]        size_a  [NUM_CH];
  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_a[i]       = ch_wr[i];
    assign size_a[i]     = ch_size[2*i +: 2];
    assign addr_a[i]     = ch_addr[ADDR_W*i +: ADDR_W];
    assign wdata_a[i]    = ch_wdata[DATA_W*i +: DATA_W];
    assign ch_addr_ok[i] = accept && (sel_g == GW'(i));
    assign ch_data_ok[i] = pop && (head_g == GW'(i));
  end

  // Scan starts at rr_ptr in round-robin mode, at 0 in fixed-priority mode.
  always_comb begin
    arb_g     = '0;
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      arb_idx = (PRIO_MODE == 1) ? GW'((int'(rr_ptr_q) + k) % NUM_CH) : GW'(k);
      if (!arb_found && ch_req[arb_idx]) begin
        arb_found = 1'b1;
        arb_g     = arb_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    m_req   = 1'b0;
    sel_g   = arb_g;
    case (state_q)
      IDLE: begin
        if (!full && (|ch_req)) begin
          m_req = 1'b1;
          if (!m_addr_ok) state_d = LOCK;
        end
      end
      LOCK: begin
        m_req = 1'b1;
        sel_g = lock_g_q;
        if (m_addr_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = m_req && m_addr_ok;
  assign m_wr     = m_req ? wr_a[sel_g]    : 1'b0;
  assign m_size   = m_req ? size_a[sel_g]  : 2'b00;
  assign m_addr   = m_req ? addr_a[sel_g]  : '0;
  assign m_wdata  = m_req ? wdata_a[sel_g] : '0;

  // Order FIFO of granted channel ids; responses return in issue order.
  assign full     = (outst_cnt == CW'(MAX_OUTST));
  assign empty    = (outst_cnt == '0);
  assign pop      = m_data_ok && !empty;
  assign head_g   = ord_mem[rd_ptr_q];
  assign ch_rdata = pop ? m_rdata : '0;

  always_ff @(posedge clk) begin
    if (accept) ord_mem[wr_ptr_q] <= sel_g;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lock_g_q  <= '0;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      outst_cnt <= '0;
      resp_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && m_req) lock_g_q <= arb_g;
      if (accept && PRIO_MODE == 1)
        rr_ptr_q <= (sel_g == GW'(NUM_CH - 1)) ? '0 : sel_g + 1'b1;
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept && !pop)      outst_cnt <= outst_cnt + 1'b1;
      else if (!accept && pop) outst_cnt <= outst_cnt - 1'b1;
      if (m_data_ok && empty) resp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: fixed-priority and round-robin instances share stimulus,
// each checked every cycle against a queue-based model plus directed constant checks.
module tb_sram_like_arbiter;
  localparam int N  = 2;
  localparam int GW = 1;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          rq_a [N];
  logic          wr_a [N];
  logic [1:0]    sz_a [N];
  logic [AW-1:0] ad_a [N];
  logic [DW-1:0] wd_a [N];
  logic [N-1:0]    ch_req, ch_wr;
  logic [2*N-1:0]  ch_size;
  logic [AW*N-1:0] ch_addr;
  logic [DW*N-1:0] ch_wdata;
  logic            m_addr_ok, m_data_ok;
  logic [DW-1:0]   m_rdata;

  logic          mreq   [2];
  logic          mwr    [2];
  logic [1:0]    msz    [2];
  logic [AW-1:0] maddr  [2];
  logic [DW-1:0] mwdata [2];
  logic [N-1:0]  aok    [2];
  logic [N-1:0]  dok    [2];
  logic [DW-1:0] rdata  [2];
  logic [CW-1:0] oc     [2];
  logic          rerr   [2];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign ch_req[i]           = rq_a[i];
    assign ch_wr[i]            = wr_a[i];
    assign ch_size[2*i +: 2]   = sz_a[i];
    assign ch_addr[AW*i +: AW] = ad_a[i];
    assign ch_wdata[DW*i +: DW] = wd_a[i];
  end

  for (genvar i = 0; i < 2; i++) begin : g_dut
    sram_like_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .PRIO_MODE(i)) dut (
      .clk(clk), .reset(reset), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(aok[i]), .ch_data_ok(dok[i]),
      .ch_rdata(rdata[i]), .m_req(mreq[i]), .m_wr(mwr[i]), .m_size(msz[i]), .m_addr(maddr[i]),
      .m_wdata(mwdata[i]), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .outst_cnt(oc[i]), .resp_err(rerr[i]));
  end

  // Reference model, one slot per instance (0 = fixed priority, 1 = round-robin).
  int ordq [2][$];
  bit locked [2];
  int lockg [2];
  int rr [2];
  bit err [2];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [63:0] o0, input logic [63:0] o1,
                          input logic [63:0] exp);
    chk({tag, "/fixed"}, o0, exp);
    chk({tag, "/rr"}, o1, exp);
  endtask

  task automatic model_grant(input bit mi, output bit req, output int g);
    int c;
    req = 1'b0;
    g   = 0;
    if (locked[mi]) begin
      req = 1'b1;
      g   = lockg[mi];
    end else if (ordq[mi].size() < MO) begin
      for (int k = 0; k < N; k++) begin
        c = mi ? (rr[mi] + k) % N : k;
        if (!req && rq_a[c[GW-1:0]]) begin
          req = 1'b1;
          g   = c;
        end
      end
    end
  endtask

  task automatic check_cycle(input bit mi);
    bit req, pop;
    int g;
    logic [GW-1:0] gi;
    logic [N-1:0] eaok, edok;
    model_grant(mi, req, g);
    gi   = g[GW-1:0];
    pop  = m_data_ok && (ordq[mi].size() > 0);
    eaok = (req && m_addr_ok) ? N'(1 << g) : '0;
    edok = pop ? N'(1 << ordq[mi][0]) : '0;
    chk($sformatf("m_req/%0d", mi), 64'(mreq[mi]), 64'(req));
    if (req) begin
      chk($sformatf("m_addr/%0d", mi), 64'(maddr[mi]), 64'(ad_a[gi]));
      chk($sformatf("m_wr/%0d", mi), 64'(mwr[mi]), 64'(wr_a[gi]));
      chk($sformatf("m_size/%0d", mi), 64'(msz[mi]), 64'(sz_a[gi]));
      chk($sformatf("m_wdata/%0d", mi), 64'(mwdata[mi]), 64'(wd_a[gi]));
    end
    chk($sformatf("ch_addr_ok/%0d", mi), 64'(aok[mi]), 64'(eaok));
    chk($sformatf("ch_data_ok/%0d", mi), 64'(dok[mi]), 64'(edok));
    if (pop) chk($sformatf("ch_rdata/%0d", mi), 64'(rdata[mi]), 64'(m_rdata));
    chk($sformatf("outst_cnt/%0d", mi), 64'(oc[mi]), 64'(ordq[mi].size()));
    chk($sformatf("resp_err/%0d", mi), 64'(rerr[mi]), 64'(err[mi]));
  endtask

  task automatic model_update(input bit mi);
    bit req;
    int g;
    int h;
    if (reset) begin
      ordq[mi].delete();
      locked[mi] = 1'b0;
      rr[mi]     = 0;
      err[mi]    = 1'b0;
      return;
    end
    model_grant(mi, req, g);
    if (m_data_ok) begin
      if (ordq[mi].size() == 0) err[mi] = 1'b1;
      else h = ordq[mi].pop_front();
    end
    if (req && m_addr_ok) begin
      ordq[mi].push_back(g);
      locked[mi] = 1'b0;
      if (mi) rr[mi] = (g + 1) % N;
    end else if (req) begin
      locked[mi] = 1'b1;
      lockg[mi]  = g;
    end
  endtask

  task automatic tick_a();
    @(negedge clk);
    if (!reset) begin
      check_cycle(1'b0);
      check_cycle(1'b1);
    end
  endtask

  task automatic tick_b();
    model_update(1'b0);
    model_update(1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    tick_a();
    tick_b();
  endtask

  task automatic set_idle();
    rq_a[0] = 1'b0; rq_a[1] = 1'b0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    for (int c = 0; c < N; c++) begin
      wr_a[c[GW-1:0]] = 1'b0; sz_a[c[GW-1:0]] = 2'd0;
      ad_a[c[GW-1:0]] = '0;   wd_a[c[GW-1:0]] = '0;
    end
    set_idle();
    cycle(); cycle();
    reset = 1'b0;

    // reset state: everything idle and zero
    tick_a();
    chk_both("rst_m_req", 64'(mreq[0]), 64'(mreq[1]), 64'd0);
    chk_both("rst_m_addr", 64'(maddr[0]), 64'(maddr[1]), 64'd0);
    chk_both("rst_cnt", 64'(oc[0]), 64'(oc[1]), 64'd0);
    chk_both("rst_err", 64'(rerr[0]), 64'(rerr[1]), 64'd0);
    chk_both("rst_aok", 64'(aok[0]), 64'(aok[1]), 64'd0);
    tick_b();

    // single read on ch1, response two cycles after acceptance
    rq_a[1] = 1'b1; sz_a[1] = 2'd2; ad_a[1] = 32'h100; m_addr_ok = 1'b1;
    tick_a();
    chk_both("t1_aok", 64'(aok[0]), 64'(aok[1]), 64'b10);
    chk_both("t1_cnt0", 64'(oc[0]), 64'(oc[1]), 64'd0);
    tick_b();
    set_idle();
    tick_a();
    chk_both("t1_cnt1", 64'(oc[0]), 64'(oc[1]), 64'd1);
    tick_b();
    m_data_ok = 1'b1; m_rdata = 32'hDEADBEEF;
    tick_a();
    chk_both("t1_dok", 64'(dok[0]), 64'(dok[1]), 64'b10);
    chk_both("t1_rdata", 64'(rdata[0]), 64'(rdata[1]), 64'hDEADBEEF);
    tick_b();
    set_idle();
    tick_a();
    chk_both("t1_cnt_end", 64'(oc[0]), 64'(oc[1]), 64'd0);
    tick_b();

    // both channels requesting: fixed priority starves ch1, round-robin alternates
    rq_a[0] = 1'b1; rq_a[1] = 1'b1; ad_a[0] = 32'h200; m_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick_a();
      chk("t2_aok/fixed", 64'(aok[0]), 64'b01);
      chk("t2_aok/rr", 64'(aok[1]), (k % 2 == 0) ? 64'b01 : 64'b10);
      tick_b();
    end
    set_idle(); m_data_ok = 1'b1;
    for (int k = 0; k < 4; k++) cycle();

    // stalled grant stays locked to ch1 while ch0 joins
    set_idle(); rq_a[1] = 1'b1; ad_a[1] = 32'hA1; ad_a[0] = 32'hA0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) rq_a[0] = 1'b1;
      tick_a();
      chk_both("t3_m_addr", 64'(maddr[0]), 64'(maddr[1]), 64'hA1);
      chk_both("t3_m_req", 64'(mreq[0]), 64'(mreq[1]), 64'd1);
      tick_b();
    end
    m_addr_ok = 1'b1;
    tick_a();
    chk_both("t3_aok", 64'(aok[0]), 64'(aok[1]), 64'b10);
    tick_b();
    rq_a[1] = 1'b0;
    cycle();
    set_idle(); m_data_ok = 1'b1;
    cycle(); cycle();

    // fill the order FIFO, then responses return to issuing channels in order
    set_idle(); m_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rq_a[0] = (k % 2 == 0); rq_a[1] = (k % 2 == 1);
      ad_a[0] = 32'h300 + 32'(k); ad_a[1] = 32'h300 + 32'(k);
      cycle();
    end
    rq_a[0] = 1'b1; rq_a[1] = 1'b0;
    tick_a();
    chk_both("t4_full_mreq", 64'(mreq[0]), 64'(mreq[1]), 64'd0);
    chk_both("t4_full_aok", 64'(aok[0]), 64'(aok[1]), 64'd0);
    chk_both("t4_full_cnt", 64'(oc[0]), 64'(oc[1]), 64'd4);
    tick_b();
    set_idle(); m_data_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_rdata = 32'(k + 1);
      tick_a();
      chk_both("t4_dok", 64'(dok[0]), 64'(dok[1]), (k % 2 == 0) ? 64'b01 : 64'b10);
      chk_both("t4_rdata", 64'(rdata[0]), 64'(rdata[1]), 64'(k + 1));
      tick_b();
    end

    // simultaneous push and pop keeps the count; stray response flags resp_err
    set_idle(); m_addr_ok = 1'b1; rq_a[0] = 1'b1;
    cycle(); cycle();
    m_data_ok = 1'b1; m_rdata = 32'h55;
    tick_a();
    chk_both("t5_cnt_pre", 64'(oc[0]), 64'(oc[1]), 64'd2);
    tick_b();
    set_idle();
    tick_a();
    chk_both("t5_cnt_post", 64'(oc[0]), 64'(oc[1]), 64'd2);
    tick_b();
    m_data_ok = 1'b1;
    cycle(); cycle();
    tick_a();
    chk_both("t5_stray_dok", 64'(dok[0]), 64'(dok[1]), 64'd0);
    chk_both("t5_err_pre", 64'(rerr[0]), 64'(rerr[1]), 64'd0);
    tick_b();
    set_idle();
    tick_a();
    chk_both("t5_err", 64'(rerr[0]), 64'(rerr[1]), 64'd1);
    tick_b();

    // reset with three outstanding
    m_addr_ok = 1'b1; rq_a[1] = 1'b1;
    cycle(); cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; set_idle();
    tick_a();
    chk_both("t6_cnt", 64'(oc[0]), 64'(oc[1]), 64'd0);
    chk_both("t6_m_req", 64'(mreq[0]), 64'(mreq[1]), 64'd0);
    chk_both("t6_err", 64'(rerr[0]), 64'(rerr[1]), 64'd0);
    tick_b();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < N; c++) begin
        rq_a[c[GW-1:0]] = ($urandom_range(0, 99) < 60);
        wr_a[c[GW-1:0]] = 1'($urandom_range(0, 1));
        sz_a[c[GW-1:0]] = 2'($urandom_range(0, 2));
        ad_a[c[GW-1:0]] = $urandom;
        wd_a[c[GW-1:0]] = $urandom;
      end
      m_addr_ok = ($urandom_range(0, 1) == 1);
      if (ordq[0].size() > 0) m_data_ok = ($urandom_range(0, 99) < 40);
      else m_data_ok = ($urandom_range(0, 99) < 3);
      m_rdata = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
